// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencing controller.
//   conv_state_t : controller state encoding (also exported on state_o)
//   RES_SEL_*    : result-port select values driven on res_sel_o
//   N_WT_ROWS    : number of weight-row beats per job
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_LOAD_D  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_WRITE_A = 3'd4,
    ST_WRITE_B = 3'd5,
    ST_DONE    = 3'd6
  } conv_state_t;

  localparam logic RES_SEL_A = 1'b0;
  localparam logic RES_SEL_B = 1'b1;

  localparam int unsigned N_WT_ROWS = 3;

endpackage

// File: rtl/conv_beat_cnt.sv
// Saturating beat counter with a loadable limit.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart at 0 and capture lim_val as the limit
//   lim_val    : limit captured on load
//   en         : count one beat (ignored once cnt reaches the limit)
//   cnt        : beats counted so far
//   tc         : the beat being counted now is the last one (cnt == limit-1)
module conv_beat_cnt
  import conv_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] lim_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] lim;
  logic [W:0]   cnt_nxt;

  // One bit wider so a limit of all-ones never aliases to zero.
  assign cnt_nxt = {1'b0, cnt} + (W+1)'(1);
  assign tc      = (cnt_nxt == {1'b0, lim});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      lim <= '0;
    end else if (load) begin
      cnt <= '0;
      lim <= lim_val;
    end else if (en && (cnt != lim)) begin
      cnt <= cnt_nxt[W-1:0];
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution job sequencer: loads 3 weight rows and cfg_len data words from
// a shared source handshake, runs the MAC for CALC_LAT cycles, then hands out
// two results (out_a, out_b) before pulsing done_o.
//   wb_clk_i, wb_rst_ni        : clock, asynchronous active-low reset
//   start_i, abort_i           : job start (IDLE only) / job cancel
//   cfg_len_i                  : data-word count, sampled on start acceptance
//   src_vld_i, src_rdy_o       : source beat handshake (weights then data)
//   wt_ld_o                    : one-hot weight-row load strobe
//   din_ld_o, din_idx_o        : data-word load strobe and index
//   mac_clr_o, mac_en_o        : accumulator clear / enable
//   res_vld_o, res_rdy_i, res_sel_o : result handshake, 0=out_a 1=out_b
//   busy_o, done_o, ovr_o      : job active, done pulse, sticky overrun
//   weight_flag_o .. out_b_flag_o : per-phase completion flags
//   state_o                    : current state encoding
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned CALC_LAT = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             src_vld_i,
  output logic             src_rdy_o,
  output logic [2:0]       wt_ld_o,
  output logic             din_ld_o,
  output logic [LEN_W-1:0] din_idx_o,
  output logic             mac_clr_o,
  output logic             mac_en_o,
  output logic             res_vld_o,
  input  logic             res_rdy_i,
  output logic             res_sel_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovr_o,
  output logic [2:0]       weight_flag_o,
  output logic             data_in_flag_o,
  output logic             out_a_flag_o,
  output logic             out_b_flag_o,
  output logic [2:0]       state_o
);

  localparam int unsigned       CALC_W   = $clog2(CALC_LAT + 1);
  localparam logic [LEN_W-1:0]  WT_BEATS = LEN_W'(N_WT_ROWS);
  localparam logic [CALC_W-1:0] CALC_LIM = CALC_W'(CALC_LAT);

  conv_state_t       state, state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic              xfer, res_acc, start_acc;
  logic              beat_load, beat_tc;
  logic [LEN_W-1:0]  beat_lim, beat_cnt;
  logic              calc_tc;
  logic [CALC_W-1:0] calc_cnt;

  // Abort wins over any handshake in the same cycle: the beat is dropped.
  assign xfer      = src_vld_i & src_rdy_o & ~abort_i;
  assign res_acc   = res_vld_o & res_rdy_i & ~abort_i;
  assign start_acc = start_i & (state == ST_IDLE);

  // One counter serves both load phases: limit 3 for weights, then reloaded
  // with the latched length on the last weight beat.
  conv_beat_cnt #(.W(LEN_W)) u_beat_cnt (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .load    (beat_load),
    .lim_val (beat_lim),
    .en      (xfer),
    .cnt     (beat_cnt),
    .tc      (beat_tc)
  );

  // Held in load outside COMPUTE so it always enters COMPUTE at zero.
  conv_beat_cnt #(.W(CALC_W)) u_calc_cnt (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .load    (state != ST_COMPUTE),
    .lim_val (CALC_LIM),
    .en      (state == ST_COMPUTE),
    .cnt     (calc_cnt),
    .tc      (calc_tc)
  );

  always_comb begin
    state_nxt = state;
    src_rdy_o = 1'b0;
    wt_ld_o   = '0;
    din_ld_o  = 1'b0;
    din_idx_o = '0;
    mac_en_o  = 1'b0;
    res_vld_o = 1'b0;
    res_sel_o = RES_SEL_A;
    done_o    = 1'b0;
    beat_load = 1'b0;
    beat_lim  = WT_BEATS;
    unique case (state)
      ST_IDLE: begin
        beat_load = 1'b1;
        if (start_i) state_nxt = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        src_rdy_o = 1'b1;
        if (xfer) begin
          wt_ld_o = 3'b001 << beat_cnt[1:0];
          if (beat_tc) begin
            beat_load = 1'b1;
            beat_lim  = len_q;
            state_nxt = (len_q == '0) ? ST_COMPUTE : ST_LOAD_D;
          end
        end
      end
      ST_LOAD_D: begin
        src_rdy_o = 1'b1;
        din_idx_o = beat_cnt;
        if (xfer) begin
          din_ld_o = 1'b1;
          if (beat_tc) state_nxt = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        mac_en_o = (calc_cnt < CALC_LIM);
        if (calc_tc) state_nxt = ST_WRITE_A;
      end
      ST_WRITE_A: begin
        res_vld_o = 1'b1;
        res_sel_o = RES_SEL_A;
        if (res_rdy_i) state_nxt = ST_WRITE_B;
      end
      ST_WRITE_B: begin
        res_vld_o = 1'b1;
        res_sel_o = RES_SEL_B;
        if (res_rdy_i) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_i && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state          <= ST_IDLE;
      len_q          <= '0;
      mac_clr_o      <= 1'b0;
      ovr_o          <= 1'b0;
      weight_flag_o  <= '0;
      data_in_flag_o <= 1'b0;
      out_a_flag_o   <= 1'b0;
      out_b_flag_o   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mac_clr_o <= start_acc;
      if (start_acc) begin
        len_q          <= cfg_len_i;
        ovr_o          <= 1'b0;
        weight_flag_o  <= '0;
        data_in_flag_o <= 1'b0;
        out_a_flag_o   <= 1'b0;
        out_b_flag_o   <= 1'b0;
      end
      if (start_i && (state != ST_IDLE)) ovr_o <= 1'b1;
      if (state == ST_LOAD_W) weight_flag_o <= weight_flag_o | wt_ld_o;
      if (xfer && beat_tc &&
          ((state == ST_LOAD_D) || ((state == ST_LOAD_W) && (len_q == '0))))
        data_in_flag_o <= 1'b1;
      if (res_acc && (state == ST_WRITE_A)) out_a_flag_o <= 1'b1;
      if (res_acc && (state == ST_WRITE_B)) out_b_flag_o <= 1'b1;
    end
  end

  assign busy_o  = (state != ST_IDLE);
  assign state_o = state;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;

  localparam int LEN_W    = 8;
  localparam int CALC_LAT = 4;

  localparam int EV_WT   = 1;
  localparam int EV_DIN  = 2;
  localparam int EV_MAC  = 3;
  localparam int EV_RES  = 4;
  localparam int EV_DONE = 5;

  logic             clk;
  logic             rst_n;
  logic             start, abort;
  logic [LEN_W-1:0] cfg_len;
  logic             src_vld, src_rdy;
  logic [2:0]       wt_ld;
  logic             din_ld;
  logic [LEN_W-1:0] din_idx;
  logic             mac_clr, mac_en;
  logic             res_vld, res_rdy, res_sel;
  logic             busy, done, ovr;
  logic [2:0]       wflag;
  logic             dflag, aflag, bflag;
  logic [2:0]       state;
  logic [28:0]      all_out;

  typedef struct packed { int kind; int val; } ev_t;
  ev_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int st_log[64];

  conv_seq_ctrl #(.LEN_W(LEN_W), .CALC_LAT(CALC_LAT)) dut (
    .wb_clk_i       (clk),
    .wb_rst_ni      (rst_n),
    .start_i        (start),
    .abort_i        (abort),
    .cfg_len_i      (cfg_len),
    .src_vld_i      (src_vld),
    .src_rdy_o      (src_rdy),
    .wt_ld_o        (wt_ld),
    .din_ld_o       (din_ld),
    .din_idx_o      (din_idx),
    .mac_clr_o      (mac_clr),
    .mac_en_o       (mac_en),
    .res_vld_o      (res_vld),
    .res_rdy_i      (res_rdy),
    .res_sel_o      (res_sel),
    .busy_o         (busy),
    .done_o         (done),
    .ovr_o          (ovr),
    .weight_flag_o  (wflag),
    .data_in_flag_o (dflag),
    .out_a_flag_o   (aflag),
    .out_b_flag_o   (bflag),
    .state_o        (state)
  );

  assign all_out = {src_rdy, wt_ld, din_ld, din_idx, mac_clr, mac_en, res_vld,
                    res_sel, busy, done, ovr, wflag, dflag, aflag, bflag, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Expected observable events of one complete job of length len.
  function automatic void push_job(input int len);
    push(EV_WT, 1); push(EV_WT, 2); push(EV_WT, 4);
    for (int i = 0; i < len; i++) push(EV_DIN, i);
    push(EV_MAC, CALC_LAT);
    push(EV_RES, 0); push(EV_RES, 1);
    push(EV_DONE, 0);
  endfunction

  task automatic observe(input int k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", k * 1024 + v, 0);
    end else begin
      e = exp_q.pop_front();
      check("event", k * 1024 + v, e.kind * 1024 + e.val);
    end
  endtask

  // Monitor: turns DUT activity into events and checks result-hold stability.
  int   mon_run = 0;
  bit   prev_wait = 0;
  logic prev_sel = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_run   = 0;
      prev_wait = 0;
    end else begin
      if (wt_ld != 3'b000) observe(EV_WT, int'(wt_ld));
      if (din_ld) observe(EV_DIN, int'(din_idx));
      if (mac_en) mon_run++;
      else if (mon_run != 0) begin
        observe(EV_MAC, mon_run);
        mon_run = 0;
      end
      if (prev_wait) check("res_hold", int'({res_vld, res_sel}), int'({1'b1, prev_sel}));
      if (res_vld && res_rdy) observe(EV_RES, int'(res_sel));
      if (done) observe(EV_DONE, 0);
      prev_wait = res_vld && !res_rdy && !abort;
      prev_sel  = res_sel;
    end
  end

  // ovr_mode: 0 none, 1 stray start in cycle 2, 2 stray start on entering COMPUTE.
  task automatic run_job(input int len, input int vld_pct, input int rdy_pct,
                         input int ovr_mode, input bit hold_a, output int lat);
    int cyc, hold, pulsed_at;
    bit exp_ovr;
    push_job(len);
    @(posedge clk); #1;
    cfg_len = LEN_W'(len);
    start   = 1'b1;
    src_vld = ($urandom_range(99) < 32'(vld_pct));
    res_rdy = ($urandom_range(99) < 32'(rdy_pct));
    cyc = 0; hold = 0; pulsed_at = -10; exp_ovr = 0; lat = -1;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start   = 1'b0;
      cfg_len = LEN_W'($urandom);
      if (cyc < 64) st_log[cyc] = int'(state);
      if (cyc == 1) begin
        check("start_state", int'(state), 1);
        check("mac_clr_pulse", int'(mac_clr), 1);
        check("flags_cleared", int'({ovr, wflag, dflag, aflag, bflag}), 0);
      end
      if (cyc == 2) check("mac_clr_one_cycle", int'(mac_clr), 0);
      if (cyc == pulsed_at + 1) check("ovr_set", int'(ovr), 1);
      if (done) begin
        lat = cyc;
        break;
      end
      if (!exp_ovr && ((ovr_mode == 1 && cyc == 2) || (ovr_mode == 2 && state == 3'd3))) begin
        start     = 1'b1;
        exp_ovr   = 1;
        pulsed_at = cyc;
      end
      src_vld = ($urandom_range(99) < 32'(vld_pct));
      res_rdy = ($urandom_range(99) < 32'(rdy_pct));
      if (hold_a && state == 3'd4 && hold < 5) begin
        res_rdy = 1'b0;
        check("hold_a_vld_sel_flag", int'({res_vld, res_sel, aflag}), 4);
        hold++;
      end
    end
    if (lat < 0) begin
      check("job_timeout", cyc, -1);
    end else begin
      @(posedge clk); #1;
      check("end_idle", int'({busy, done, state}), 0);
      check("end_flags", int'({wflag, dflag, aflag, bflag}), 7 * 8 + 7);
      check("end_ovr", int'(ovr), int'(exp_ovr));
      check("end_queue_empty", exp_q.size(), 0);
    end
  endtask

  initial begin
    int lat, n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_len = '0;
    src_vld = 1'b0; res_rdy = 1'b0;
    #3;
    check("reset_outputs", int'(all_out), 0);
    #20 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full job, handshakes always ready.
    run_job(4, 100, 100, 0, 0, lat);
    check("latency_len4", lat, 14);

    // Zero length skips data loading.
    run_job(0, 100, 100, 0, 0, lat);
    check("len0_state_c3", st_log[3], 1);
    check("len0_state_c4", st_log[4], 3);
    check("len0_latency", lat, 10);

    // Result back-pressure in WRITE_A.
    run_job(3, 100, 100, 0, 1, lat);
    check("hold_latency", lat, 18);

    // Stray start during COMPUTE; next job must clear ovr (checked at cycle 1).
    run_job(2, 100, 100, 2, 0, lat);
    run_job(1, 100, 100, 0, 0, lat);

    // Abort coinciding with data beat 2.
    push(EV_WT, 1); push(EV_WT, 2); push(EV_WT, 4);
    push(EV_DIN, 0); push(EV_DIN, 1);
    @(posedge clk); #1;
    cfg_len = 8'd4; start = 1'b1; src_vld = 1'b1; res_rdy = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end while (!(state == 3'd2 && din_idx == 8'd2) && n < 30);
    check("abort_reached_beat2", n, 6);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_state", int'(state), 0);
    check("abort_flags", int'({wflag, dflag, aflag, bflag}), 7 * 8);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", int'(done), 0);
      @(posedge clk); #1;
    end
    check("abort_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of LOAD_D.
    push(EV_WT, 1); push(EV_WT, 2); push(EV_WT, 4);
    push(EV_DIN, 0); push(EV_DIN, 1);
    cfg_len = 8'd5; start = 1'b1; src_vld = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end while (!(state == 3'd2 && din_idx == 8'd2) && n < 30);
    check("reset_reached_beat2", n, 6);
    #2 rst_n = 1'b0;
    #1 check("reset_async_outputs", int'(all_out), 0);
    @(posedge clk); #1;
    check("reset_held_outputs", int'(all_out), 0);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_no_done", int'({done, busy}), 0);
    check("reset_queue_empty", exp_q.size(), 0);
    run_job(2, 100, 100, 0, 0, lat);

    // Randomized jobs.
    for (int j = 0; j < 15; j++) begin
      run_job(int'($urandom_range(0, 9)), int'($urandom_range(40, 100)),
              int'($urandom_range(30, 100)), int'($urandom_range(0, 2)),
              bit'($urandom_range(0, 1)), lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the data-word count and index.
REQ-002 SHALL have parameter CALC_LAT, default 4: COMPUTE duration in cycles, minimum 1.
REQ-003 SHALL have ports: wb_clk_i  in  1  sole clock, rising edge.
REQ-004 wb_rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  single-cycle job start request.
REQ-006 abort_i  in  1  job cancel request.
REQ-007 cfg_len_i  in  LEN_W  data-word count for the job, sampled on start acceptance.
REQ-008 src_vld_i / src_rdy_o  in / out  1 each  source beat handshake, used for weights and data.
REQ-009 wt_ld_o  out  3  one-hot weight-row load strobe.
REQ-010 din_ld_o  out  1  data-word load strobe; din_idx_o  out  LEN_W  word index.
REQ-011 mac_clr_o, mac_en_o  out  1 each  accumulator clear and enable.
REQ-012 res_vld_o / res_rdy_i  out / in  1 each  result handshake; res_sel_o  out  1  0=out_a, 1=out_b.
REQ-013 busy_o, done_o, ovr_o  out  1 each  job active, done pulse, sticky overrun.
REQ-014 weight_flag_o  out  3; data_in_flag_o, out_a_flag_o, out_b_flag_o  out  1 each; state_o  out  3  current state encoding.

Function
REQ-015 State machine SHALL be: IDLE(0), LOAD_W(1), LOAD_D(2), COMPUTE(3), WRITE_A(4), WRITE_B(5), DONE(6).
REQ-016 In IDLE, start_i=1 SHALL be accepted and SHALL, on the next edge: latch cfg_len_i, clear all flags and ovr_o, pulse mac_clr_o for one cycle, and enter LOAD_W.
REQ-017 src_rdy_o SHALL be 1 only in LOAD_W and LOAD_D; a beat transfers on a cycle with src_vld_i & src_rdy_o.
REQ-018 LOAD_W: beat k (k=0..2) SHALL drive wt_ld_o = 1<<k combinationally in the transfer cycle and set weight_flag_o[k] on the next edge; after beat 2 go to LOAD_D.
REQ-019 LOAD_D: each beat SHALL assert din_ld_o with din_idx_o = 0,1,...,len-1; after beat len-1 set data_in_flag_o and enter COMPUTE.
REQ-020 A latched length of 0 SHALL skip LOAD_D: LOAD_W goes straight to COMPUTE with data_in_flag_o set.
REQ-021 COMPUTE SHALL hold mac_en_o=1 for exactly CALC_LAT cycles, then go to WRITE_A.
REQ-022 WRITE_A/WRITE_B SHALL hold res_vld_o=1 with res_sel_o=0/1 until res_rdy_i; on acceptance set out_a_flag_o/out_b_flag_o and advance to WRITE_B/DONE.
REQ-023 res_vld_o SHALL NOT drop before acceptance.
REQ-024 DONE SHALL last one cycle with done_o=1, then return to IDLE; flags SHALL hold until the next accepted start.
REQ-025 busy_o SHALL be 1 in every state except IDLE.
REQ-026 start_i while busy_o=1 SHALL be ignored and SHALL set ovr_o.
REQ-027 abort_i in any non-IDLE state SHALL return to IDLE on the next edge with no done_o pulse and flags frozen; abort_i has priority over a same-cycle handshake, and that handshake's beat is dropped.
REQ-028 Counters SHALL NOT wrap: the beat counter saturates at the latched length; COMPUTE uses a separate counter of width clog2(CALC_LAT+1).
REQ-029 Strobes (wt_ld_o, din_ld_o, mac_*, done_o) SHALL be 0 outside their states.

Reset
REQ-030 wb_rst_ni=0 SHALL immediately force IDLE and drive every output to 0, including all flags, ovr_o, din_idx_o and state_o.
REQ-031 Reset mid-job SHALL discard the job; no done_o follows deassertion.

Structure
REQ-032 The state encoding and the res_sel constants SHALL live in the shared package conv_pkg.
REQ-033 Beat counting SHALL be one sub-module, conv_beat_cnt (load, enable, terminal-count output), instantiated for the weight/data beats and for COMPUTE.

Verification
REQ-034 Scenario: len=4, src_vld_i=1 and res_rdy_i=1 throughout -> wt_ld_o=1,2,4; din_idx_o=0..3; mac_en_o high 4 cycles; done_o 14 cycles after start.
REQ-035 Scenario: len=0 -> no din_ld_o; data_in_flag_o=1; state sequence 1->3.
REQ-036 Scenario: res_rdy_i held 0 for 5 cycles in WRITE_A -> res_vld_o stable, res_sel_o=0, out_a_flag_o=0 until acceptance.
REQ-037 Scenario: start_i pulsed during COMPUTE -> ovr_o=1; job completes normally; the next start clears ovr_o.
REQ-038 Scenario: abort_i together with data beat 2 -> IDLE next cycle; weight_flag_o=7; data_in_flag_o=0; no done_o.
REQ-039 Scenario: wb_rst_ni low mid-LOAD_D -> all outputs 0 asynchronously; a fresh start runs from LOAD_W.
